// File: rtl/ext_bus_bridge.sv
// Bridges one core access at a time onto a valid/ready external bus.
// The core is stalled while the access is outstanding; a watchdog ends accesses the device never acknowledges.
module ext_bus_bridge #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_en,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        core_stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [15:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  // Counter value on the last REQ cycle the device is allowed before the watchdog fires.
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam bit               TO_EN   = (TIMEOUT != 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             timeout_hit;

  assign timeout_hit = TO_EN && (cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      core_stall <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      bus_valid  <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          if (ex_en) begin
            bus_we     <= req_we;
            bus_addr   <= req_addr;
            bus_wdata  <= req_wdata;
            bus_valid  <= 1'b1;
            core_stall <= 1'b1;
            cnt        <= '0;
            state      <= REQ;
          end
        end
        REQ: begin
          if (cnt != '1) cnt <= cnt + 1'b1;
          // A handshake on the same edge as the watchdog expiry is still a success.
          if (bus_ready) begin
            bus_valid  <= 1'b0;
            core_stall <= 1'b0;
            if (!bus_we) rsp_rdata <= bus_rdata;
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b0;
            state      <= DONE;
          end else if (timeout_hit) begin
            bus_valid  <= 1'b0;
            core_stall <= 1'b0;
            rsp_rdata  <= 32'hDEAD_BEEF;
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_bus_bridge.sv
// Scenario bench for ext_bus_bridge with a transaction-level reference model (watchdog = 4 cycles).
module tb_ext_bus_bridge;
  localparam int TO = 4;

  logic        clk = 0;
  logic        rst = 0;
  logic        ex_en = 0, req_we = 0;
  logic [15:0] req_addr = 0;
  logic [31:0] req_wdata = 0;
  logic        core_stall, rsp_valid, rsp_err, bus_valid, bus_we;
  logic [31:0] rsp_rdata, bus_wdata;
  logic [15:0] bus_addr;
  logic        bus_ready = 0;
  logic [31:0] bus_rdata = 0;

  int total = 0, bad = 0;
  logic [31:0] last_rd;

  ext_bus_bridge #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ex_en(ex_en), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .core_stall(core_stall), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .bus_valid(bus_valid), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // Drives one access; acknowledges on REQ cycle rdy_at (0 = never) and records what the bus and response did.
  task automatic do_txn(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                        input int rdy_at, input logic [31:0] rd,
                        output int vcyc, output int scyc, output logic stable,
                        output logic got, output logic [31:0] o_rd, output logic o_err,
                        output logic pulse2, output logic [31:0] held);
    int k;
    @(negedge clk);
    ex_en = 1; req_we = we; req_addr = addr; req_wdata = wd; bus_ready = 0;
    @(negedge clk);
    ex_en = 0; req_we = ~we; req_addr = ~addr; req_wdata = ~wd;
    vcyc = 0; scyc = 0; stable = 1; k = 1;
    while (bus_valid === 1'b1 && k < 64) begin
      vcyc++;
      if (core_stall === 1'b1) scyc++;
      if (bus_we !== we || bus_addr !== addr || bus_wdata !== wd) stable = 0;
      bus_ready = (k == rdy_at); bus_rdata = rd;
      @(negedge clk); k++;
    end
    bus_ready = 0; bus_rdata = $urandom;
    got = rsp_valid; o_rd = rsp_rdata; o_err = rsp_err;
    @(negedge clk);
    pulse2 = rsp_valid; held = rsp_rdata;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({bus_valid, bus_we, core_stall, rsp_valid, rsp_err} !== 5'b0 ||
        bus_addr !== 16'h0 || bus_wdata !== 32'h0 || rsp_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: bv=%b we=%b st=%b rv=%b err=%b addr=%h wd=%h rd=%h, want all 0",
               bus_valid, bus_we, core_stall, rsp_valid, rsp_err, bus_addr, bus_wdata, rsp_rdata);
    end
    @(negedge clk); rst = 1;
    last_rd = 32'h0;
  endtask

  task automatic test_read_zero_wait();
    int v, s; logic st, g, e, p2; logic [31:0] r, h;
    do_txn(1'b0, 16'h4010, 32'h5555_AAAA, 1, 32'h1234_5678, v, s, st, g, r, e, p2, h);
    total++; if (v !== 1) begin bad++; $display("FAIL rd0_valid_cycles: got %0d want 1", v); end
    total++; if (s !== 1) begin bad++; $display("FAIL rd0_stall_cycles: got %0d want 1", s); end
    total++; if (st !== 1'b1) begin bad++; $display("FAIL rd0_bus_fields: got unstable/wrong want stable"); end
    total++; if ({g, e} !== 2'b10) begin bad++; $display("FAIL rd0_rsp: got valid=%b err=%b want 1 0", g, e); end
    total++; if (r !== 32'h1234_5678) begin bad++; $display("FAIL rd0_rdata: got %h want 12345678", r); end
    total++; if (p2 !== 1'b0 || h !== 32'h1234_5678) begin bad++; $display("FAIL rd0_pulse_hold: got valid=%b rdata=%h want 0 12345678", p2, h); end
    last_rd = 32'h1234_5678;
  endtask

  task automatic test_write_wait();
    int v, s; logic st, g, e, p2; logic [31:0] r, h;
    do_txn(1'b1, 16'h8000, 32'hCAFE_0001, 4, 32'h7777_7777, v, s, st, g, r, e, p2, h);
    total++; if (v !== 4 || s !== 4) begin bad++; $display("FAIL wr_cycles: got valid=%0d stall=%0d want 4 4", v, s); end
    total++; if (st !== 1'b1) begin bad++; $display("FAIL wr_bus_fields: got unstable/wrong want stable"); end
    total++; if ({g, e, p2} !== 3'b100) begin bad++; $display("FAIL wr_rsp: got valid=%b err=%b next=%b want 1 0 0", g, e, p2); end
    total++; if (r !== last_rd) begin bad++; $display("FAIL wr_rdata_kept: got %h want %h", r, last_rd); end
  endtask

  task automatic test_timeout();
    int v, s; logic st, g, e, p2; logic [31:0] r, h;
    do_txn(1'b0, 16'hC123, 32'h0, 0, 32'h1111_2222, v, s, st, g, r, e, p2, h);
    total++; if (v !== TO || s !== TO) begin bad++; $display("FAIL to_cycles: got valid=%0d stall=%0d want %0d", v, s, TO); end
    total++; if ({g, e} !== 2'b11) begin bad++; $display("FAIL to_rsp: got valid=%b err=%b want 1 1", g, e); end
    total++; if (r !== 32'hDEAD_BEEF) begin bad++; $display("FAIL to_rdata: got %h want deadbeef", r); end
    total++; if (p2 !== 1'b0 || h !== 32'hDEAD_BEEF) begin bad++; $display("FAIL to_pulse_hold: got valid=%b rdata=%h want 0 deadbeef", p2, h); end
    last_rd = 32'hDEAD_BEEF;
  endtask

  task automatic test_tie();
    int v, s; logic st, g, e, p2; logic [31:0] r, h;
    do_txn(1'b0, 16'h4ABC, 32'h0, TO, 32'h0BAD_F00D, v, s, st, g, r, e, p2, h);
    total++; if (v !== TO) begin bad++; $display("FAIL tie_cycles: got %0d want %0d", v, TO); end
    total++; if ({g, e} !== 2'b10 || r !== 32'h0BAD_F00D) begin bad++; $display("FAIL tie_rsp: got valid=%b err=%b rdata=%h want 1 0 0badf00d", g, e, r); end
    last_rd = 32'h0BAD_F00D;
  endtask

  task automatic test_ready_idle();
    int seen = 0;
    @(negedge clk); ex_en = 0; bus_ready = 1; bus_rdata = 32'hFFFF_0000;
    repeat (3) begin
      @(negedge clk);
      if (bus_valid !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== last_rd) seen++;
    end
    bus_ready = 0;
    total++; if (seen !== 0) begin bad++; $display("FAIL ready_while_idle: got %0d disturbed cycles want 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic vld[5], rv[5]; logic [15:0] ad[5]; logic [31:0] rdv[5];
    @(negedge clk); ex_en = 1; req_we = 0; req_addr = 16'h4000; bus_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vld[i] = bus_valid; rv[i] = rsp_valid; ad[i] = bus_addr; rdv[i] = rsp_rdata;
      if (bus_valid === 1'b1) begin
        bus_ready = 1; bus_rdata = 32'hB0B0_0000 + i; req_addr = 16'h4004;
      end else bus_ready = 0;
      if (i == 3) ex_en = 0;
    end
    bus_ready = 0;
    total++;
    if ({vld[0], vld[1], vld[2], vld[3], vld[4]} !== 5'b10010) begin
      bad++; $display("FAIL b2b_valid_seq: got %b%b%b%b%b want 10010", vld[0], vld[1], vld[2], vld[3], vld[4]);
    end
    total++;
    if ({rv[0], rv[1], rv[2], rv[3], rv[4]} !== 5'b01001) begin
      bad++; $display("FAIL b2b_rsp_seq: got %b%b%b%b%b want 01001", rv[0], rv[1], rv[2], rv[3], rv[4]);
    end
    total++; if (ad[0] !== 16'h4000 || ad[3] !== 16'h4004) begin bad++; $display("FAIL b2b_addr: got %h %h want 4000 4004", ad[0], ad[3]); end
    total++; if (rdv[1] !== 32'hB0B0_0000 || rdv[4] !== 32'hB0B0_0003) begin bad++; $display("FAIL b2b_rdata: got %h %h want b0b00000 b0b00003", rdv[1], rdv[4]); end
    last_rd = 32'hB0B0_0003;
  endtask

  task automatic test_async_reset();
    int v, s; logic st, g, e, p2; logic [31:0] r, h;
    @(negedge clk); ex_en = 1; req_we = 1; req_addr = 16'h9000; req_wdata = 32'h1; bus_ready = 0;
    @(negedge clk); ex_en = 0;
    total++; if (bus_valid !== 1'b1) begin bad++; $display("FAIL arst_pre: got bus_valid=%b want 1", bus_valid); end
    #2 rst = 0;
    #1;
    total++;
    if ({bus_valid, core_stall, rsp_valid} !== 3'b000) begin
      bad++; $display("FAIL arst_immediate: got bv=%b st=%b rv=%b want 000", bus_valid, core_stall, rsp_valid);
    end
    @(negedge clk); rst = 1;
    @(negedge clk);
    total++;
    if ({bus_valid, core_stall, rsp_valid} !== 3'b000 || rsp_rdata !== 32'h0) begin
      bad++; $display("FAIL arst_after: got bv=%b st=%b rv=%b rd=%h want 000 0", bus_valid, core_stall, rsp_valid, rsp_rdata);
    end
    last_rd = 32'h0;
    do_txn(1'b0, 16'h4444, 32'h0, 1, 32'hA5A5_5A5A, v, s, st, g, r, e, p2, h);
    total++; if (v !== 1 || g !== 1'b1 || r !== 32'hA5A5_5A5A) begin bad++; $display("FAIL arst_idle_restart: got cycles=%0d valid=%b rdata=%h want 1 1 a5a55a5a", v, g, r); end
    last_rd = 32'hA5A5_5A5A;
  endtask

  // Model: acknowledged within TO cycles -> success after rdy_at cycles; otherwise error after TO cycles.
  task automatic test_random();
    int v, s, rdy, exp_v; logic st, g, e, p2, we, exp_err; logic [31:0] r, h, wd, rd, exp_rd;
    logic [15:0] addr;
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom); addr = {2'($urandom_range(1, 3)), 14'($urandom)};
      wd = $urandom; rd = $urandom; rdy = $urandom_range(0, 6);
      if (rdy >= 1 && rdy <= TO) begin
        exp_v = rdy; exp_err = 0; exp_rd = we ? last_rd : rd;
      end else begin
        exp_v = TO; exp_err = 1; exp_rd = 32'hDEAD_BEEF;
      end
      do_txn(we, addr, wd, rdy, rd, v, s, st, g, r, e, p2, h);
      total++;
      if (v !== exp_v || s !== exp_v || st !== 1'b1 || g !== 1'b1 || e !== exp_err ||
          r !== exp_rd || p2 !== 1'b0 || h !== exp_rd) begin
        bad++;
        $display("FAIL rand_%0d: got cyc=%0d stall=%0d stable=%b rv=%b err=%b rd=%h next=%b held=%h want cyc=%0d err=%b rd=%h",
                 n, v, s, st, g, e, r, p2, h, exp_v, exp_err, exp_rd);
      end
      last_rd = exp_rd;
    end
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_timeout();
    test_tie();
    test_ready_idle();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
